// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART TX arbiter: FSM states, the line terminator
// and the ceiling-log2 helper used to size counters.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam logic [7:0] NEWLINE = 8'h0A;

   // Owner index width; covers up to 8 requesters.
   localparam int IDX_W = 3;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: finds the first set request bit
// searching upward from (ptr+1) mod N with wrap-around.
module rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic             any,
   output logic [IDX_W-1:0] idx,
   output logic [N-1:0]     onehot
);

   always_comb begin
      any    = 1'b0;
      idx    = '0;
      onehot = '0;
      for (int i = 1; i <= N; i++) begin
         if (!any && req[(int'(ptr) + i) % N]) begin
            any = 1'b1;
            idx = IDX_W'((int'(ptr) + i) % N);
         end
      end
      if (any) begin
         onehot = N'(1) << idx;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Line-atomic round-robin arbiter sharing one UART transmitter between
// N_REQ byte-stream requesters through a single-byte holding register.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int HOLD_TIMEOUT = 1024,
   parameter int LINE_LOCK    = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N_REQ-1:0]     req_valid_i,
   input  logic [8*N_REQ-1:0]   req_data_i,
   output logic [N_REQ-1:0]     req_ready_o,
   output logic                 tx_valid_o,
   output logic [7:0]           tx_data_o,
   input  logic                 tx_ready_i,
   output logic [N_REQ-1:0]     grant_o,
   output logic [2:0]           owner_o
);

   localparam int CNT_W = (HOLD_TIMEOUT > 0) ? clog2(HOLD_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (HOLD_TIMEOUT > 0) ? CNT_W'(HOLD_TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(N_REQ - 1);

   state_t             state, state_nxt;
   logic [N_REQ-1:0]   grant, grant_nxt;
   logic [IDX_W-1:0]   owner, owner_nxt;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic               tx_valid, tx_valid_nxt;
   logic [7:0]         tx_data, tx_data_nxt;

   logic               pick_any;
   logic [IDX_W-1:0]   pick_idx;
   logic [N_REQ-1:0]   pick_onehot;

   logic               owner_valid;
   logic [7:0]         owner_byte;
   logic               accept;
   logic               tx_done;

   rr_pick #(
      .N(N_REQ)
   ) u_pick (
      .req    (req_valid_i),
      .ptr    (rr_ptr),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

   always_comb begin
      owner_byte = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant[k]) begin
            owner_byte = req_data_i[8*k +: 8];
         end
      end
   end

   assign owner_valid = |(req_valid_i & grant);
   assign accept      = (state == ST_LOCK) && !tx_valid && owner_valid;
   assign tx_done     = tx_valid && tx_ready_i;

   assign req_ready_o = ((state == ST_LOCK) && !tx_valid) ? grant : '0;
   assign tx_valid_o  = tx_valid;
   assign tx_data_o   = tx_data;
   assign grant_o     = grant;
   assign owner_o     = owner;

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      owner_nxt    = owner;
      rr_ptr_nxt   = rr_ptr;
      count_nxt    = count;
      tx_data_nxt  = tx_data;
      tx_valid_nxt = tx_done ? 1'b0 : tx_valid;

      case (state)
         ST_IDLE: begin
            if (pick_any) begin
               state_nxt  = ST_LOCK;
               grant_nxt  = pick_onehot;
               owner_nxt  = pick_idx;
               rr_ptr_nxt = pick_idx;
               count_nxt  = '0;
            end
         end

         ST_LOCK: begin
            if (accept) begin
               tx_data_nxt  = owner_byte;
               tx_valid_nxt = 1'b1;
               count_nxt    = '0;
               if ((LINE_LOCK == 0) || (owner_byte == NEWLINE)) begin
                  state_nxt = ST_DRAIN;
               end
            end else if (!owner_valid) begin
               // A stalled owner still presenting a byte is not idle.
               if (count != CNT_MAX) begin
                  count_nxt = count + CNT_W'(1);
               end
               if ((HOLD_TIMEOUT > 0) && (count == CNT_LAST)) begin
                  state_nxt = ST_DRAIN;
               end
            end
         end

         ST_DRAIN: begin
            if (!tx_valid || tx_ready_i) begin
               state_nxt = ST_IDLE;
               grant_nxt = '0;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            grant_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         grant    <= '0;
         owner    <= '0;
         rr_ptr   <= PTR_INIT;
         count    <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         owner    <= owner_nxt;
         rr_ptr   <= rr_ptr_nxt;
         count    <= count_nxt;
         tx_valid <= tx_valid_nxt;
         tx_data  <= tx_data_nxt;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: line-locked instance (timeout 16) and a
// byte-level round-robin instance.
module tb_uart_tx_arbiter;

   logic        clk = 1'b0;
   logic        rst;

   logic [3:0]  va;
   logic [31:0] da;
   logic        tra;
   logic [3:0]  rdy_a;
   logic        txv_a;
   logic [7:0]  txd_a;
   logic [3:0]  gnt_a;
   logic [2:0]  own_a;

   logic [3:0]  vb;
   logic [31:0] db;
   logic        trb;
   logic [3:0]  rdy_b;
   logic        txv_b;
   logic [7:0]  txd_b;
   logic [3:0]  gnt_b;
   logic [2:0]  own_b;

   int checks   = 0;
   int failures = 0;

   logic [7:0] lane_bytes [4][8];
   int         lane_len [4];
   logic [7:0] rx_q [$];
   logic [3:0] gnt_q [$];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.N_REQ(4), .HOLD_TIMEOUT(16), .LINE_LOCK(1)) dut_a (
      .clk_i(clk), .rst_i(rst), .req_valid_i(va), .req_data_i(da),
      .req_ready_o(rdy_a), .tx_valid_o(txv_a), .tx_data_o(txd_a),
      .tx_ready_i(tra), .grant_o(gnt_a), .owner_o(own_a)
   );

   uart_tx_arbiter #(.N_REQ(4), .HOLD_TIMEOUT(16), .LINE_LOCK(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .req_valid_i(vb), .req_data_i(db),
      .req_ready_o(rdy_b), .tx_valid_o(txv_b), .tx_data_o(txd_b),
      .tx_ready_i(trb), .grant_o(gnt_b), .owner_o(own_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Drives lanes from lane_bytes until every lane is consumed and the
   // selected arbiter has returned to idle; logs tx bytes and grants.
   task automatic run_stream(input bit sel, input int max_cyc);
      int         pos [4];
      int         cyc;
      bit         done;
      logic [3:0] v, r, g, gprev;
      logic [31:0] d;
      logic       tv;
      logic [7:0] td;
      for (int k = 0; k < 4; k++) pos[k] = 0;
      gprev = '0;
      done  = 1'b0;
      cyc   = 0;
      while (!done && cyc < max_cyc) begin
         v = '0;
         d = '0;
         for (int k = 0; k < 4; k++) begin
            if (pos[k] < lane_len[k]) begin
               v[k] = 1'b1;
               d[8*k +: 8] = lane_bytes[k][pos[k]];
            end
         end
         if (!sel) begin va = v; da = d; tra = 1'b1; end
         else      begin vb = v; db = d; trb = 1'b1; end
         #1;
         r  = sel ? rdy_b : rdy_a;
         g  = sel ? gnt_b : gnt_a;
         tv = sel ? txv_b : txv_a;
         td = sel ? txd_b : txd_a;
         if (tv) rx_q.push_back(td);
         if (g != 4'b0 && g != gprev) gnt_q.push_back(g);
         gprev = g;
         done = !tv && (g == 4'b0);
         for (int k = 0; k < 4; k++) begin
            if (v[k] && r[k]) pos[k]++;
            if (pos[k] < lane_len[k]) done = 1'b0;
         end
         tick();
         cyc++;
      end
      chk("stream_done", 32'(done), 32'd1);
      if (!sel) va = '0; else vb = '0;
   endtask

   task automatic chk_rx(input string tag, input logic [7:0] exp [$]);
      chk($sformatf("%s_len", tag), rx_q.size(), exp.size());
      for (int i = 0; i < exp.size(); i++) begin
         chk($sformatf("%s_byte%0d", tag, i),
             (i < rx_q.size()) ? 32'(rx_q[i]) : 32'hFFFF, 32'(exp[i]));
      end
   endtask

   initial begin
      logic [7:0] exp2 [$];
      logic [7:0] exp6 [$];
      bit         hold_ok;

      va = '0; da = '0; tra = 1'b1;
      vb = '0; db = '0; trb = 1'b1;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_grant", gnt_a, 4'b0000);
      chk("rst_owner", own_a, 3'd0);
      chk("rst_txv", txv_a, 1'b0);
      chk("rst_txd", txd_a, 8'h00);
      chk("rst_ready", rdy_a, 4'b0000);
      chk("rst_grant_b", gnt_b, 4'b0000);

      // 1: req0 sends "A\n"
      da[7:0] = 8'h41; va = 4'b0001;
      tick();
      chk("t1_grant", gnt_a, 4'b0001);
      chk("t1_ready", rdy_a, 4'b0001);
      chk("t1_txv_grant_cycle", txv_a, 1'b0);
      tick();
      chk("t1_txv_A", txv_a, 1'b1);
      chk("t1_txd_A", txd_a, 8'h41);
      chk("t1_ready_busy", rdy_a, 4'b0000);
      da[7:0] = 8'h0A;
      tick();
      chk("t1_txv_A_one_cycle", txv_a, 1'b0);
      chk("t1_ready_again", rdy_a, 4'b0001);
      tick();
      chk("t1_txv_nl", txv_a, 1'b1);
      chk("t1_txd_nl", txd_a, 8'h0A);
      chk("t1_grant_drain", gnt_a, 4'b0001);
      chk("t1_ready_drain", rdy_a, 4'b0000);
      va = '0;
      tick();
      chk("t1_txv_done", txv_a, 1'b0);
      chk("t1_released", gnt_a, 4'b0000);

      // 2: req1 "X\n" and req2 "Y\n" from the same cycle
      for (int k = 0; k < 4; k++) lane_len[k] = 0;
      lane_bytes[1][0] = 8'h58; lane_bytes[1][1] = 8'h0A; lane_len[1] = 2;
      lane_bytes[2][0] = 8'h59; lane_bytes[2][1] = 8'h0A; lane_len[2] = 2;
      rx_q.delete();
      gnt_q.delete();
      run_stream(1'b0, 200);
      exp2 = '{8'h58, 8'h0A, 8'h59, 8'h0A};
      chk_rx("t2", exp2);
      chk("t2_ngrants", gnt_q.size(), 2);
      chk("t2_first_grant", (gnt_q.size() > 0) ? 32'(gnt_q[0]) : 32'hF, 4'b0010);
      chk("t2_second_grant", (gnt_q.size() > 1) ? 32'(gnt_q[1]) : 32'hF, 4'b0100);

      // 3: req0 sends "a" then goes quiet; req3 waits for the timeout
      da = '0; da[7:0] = 8'h61; va = 4'b0001;
      tick();
      chk("t3_grant", gnt_a, 4'b0001);
      tick();
      chk("t3_txd", txd_a, 8'h61);
      va = 4'b1000; da = '0; da[31:24] = 8'h0A;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 15) begin
            chk("t3_held_15", gnt_a, 4'b0001);
            chk("t3_ready_15", rdy_a, 4'b0001);
         end
         if (i == 16) begin
            chk("t3_held_16", gnt_a, 4'b0001);
            chk("t3_drain_16", rdy_a, 4'b0000);
         end
      end
      tick();
      chk("t3_released", gnt_a, 4'b0000);
      tick();
      chk("t3_req3_grant", gnt_a, 4'b1000);
      chk("t3_req3_owner", own_a, 3'd3);
      tick();
      chk("t3_req3_txd", txd_a, 8'h0A);
      va = '0;
      tick();
      chk("t3_req3_release", gnt_a, 4'b0000);

      // 4: UART stalls for 50 cycles with 0x55 held
      tra = 1'b0;
      da = '0; da[15:8] = 8'h55; va = 4'b0010;
      tick();
      chk("t4_grant", gnt_a, 4'b0010);
      tick();
      chk("t4_txd", txd_a, 8'h55);
      da[15:8] = 8'h0A;
      hold_ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (!(txv_a === 1'b1 && txd_a === 8'h55 && rdy_a === 4'b0000 && gnt_a === 4'b0010))
            hold_ok = 1'b0;
      end
      chk("t4_stall_stable", 32'(hold_ok), 32'd1);
      tra = 1'b1;
      tick();
      chk("t4_complete", txv_a, 1'b0);
      chk("t4_ready_after", rdy_a, 4'b0010);
      tick();
      chk("t4_nl_txd", txd_a, 8'h0A);
      va = '0;
      tick();
      chk("t4_release", gnt_a, 4'b0000);

      // 5: reset mid-line with a byte held
      tra = 1'b0;
      da = '0; da[23:16] = 8'h51; va = 4'b0100;
      tick();
      chk("t5_grant", gnt_a, 4'b0100);
      tick();
      chk("t5_txv_held", txv_a, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_rst_txv", txv_a, 1'b0);
      chk("t5_rst_grant", gnt_a, 4'b0000);
      chk("t5_rst_txd", txd_a, 8'h00);
      da = {8'h33, 8'h32, 8'h31, 8'h0A};
      va = 4'b1101;
      tra = 1'b1;
      tick();
      chk("t5_req0_first", gnt_a, 4'b0001);
      chk("t5_owner0", own_a, 3'd0);
      va = 4'b0001;
      tick();
      chk("t5_nl", txd_a, 8'h0A);
      va = '0;
      tick();
      chk("t5_release", gnt_a, 4'b0000);

      // 6: byte-level round robin, four streaming requesters
      for (int k = 0; k < 4; k++) begin
         lane_len[k] = 3;
         for (int j = 0; j < 3; j++) lane_bytes[k][j] = 8'(k * 16 + j);
      end
      rx_q.delete();
      gnt_q.delete();
      run_stream(1'b1, 300);
      exp6 = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31,
               8'h02, 8'h12, 8'h22, 8'h32};
      chk_rx("t6", exp6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
